// File: rtl/mem_axis_pkg.sv
// Shared types and helpers for the memory-to-AXI-Stream reader:
// FSM state encoding, beat geometry and byte-qualifier generation.
package mem_axis_pkg;

    localparam int AXIS_TDATA_WIDTH = 32;
    localparam int BYTES_PER_BEAT   = AXIS_TDATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_VALID   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Low n lanes qualified, remaining lanes cleared.
    function automatic logic [BYTES_PER_BEAT-1:0] strb_from_count(input logic [2:0] n);
        logic [BYTES_PER_BEAT-1:0] s;
        case (n)
            3'd0:    s = 4'b0000;
            3'd1:    s = 4'b0001;
            3'd2:    s = 4'b0011;
            3'd3:    s = 4'b0111;
            3'd4:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_to_axis_reader_if.sv
// AXI-Stream beat bundle driven by the reader (master) toward a downstream sink (slave).
interface mem_to_axis_reader_if
    import mem_axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_TDATA_WIDTH
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mem_axis_byte_packer.sv
// Four-lane byte register: cleared at beat start, filled one lane per captured
// memory byte, and carrying the byte-qualifier pattern for the beat being built.
module mem_axis_byte_packer
    import mem_axis_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [2:0]                    beat_n,
    input  logic                          capture_en,
    input  logic [1:0]                    lane,
    input  logic [7:0]                    byte_in,
    output logic [AXIS_TDATA_WIDTH-1:0]   data,
    output logic [BYTES_PER_BEAT-1:0]     strb
);

    logic [BYTES_PER_BEAT-1:0][7:0] lanes_r;
    logic [BYTES_PER_BEAT-1:0]      strb_r;

    // Lane storage; clearing zeroes unused lanes of a short final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_r <= '0;
            strb_r  <= '0;
        end else if (clear) begin
            lanes_r <= '0;
            strb_r  <= strb_from_count(beat_n);
        end else if (capture_en) begin
            lanes_r[lane] <= byte_in;
        end else begin
            lanes_r <= lanes_r;
        end
    end

    assign data = lanes_r;
    assign strb = strb_r;

endmodule

// File: rtl/mem_to_axis_reader.sv
// Reads byte_count bytes starting at base_addr from a byte-wide memory and
// emits them as little-endian packed 32-bit AXI-Stream beats with tstrb/tlast.
module mem_to_axis_reader
    import mem_axis_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH         = 16
)
(
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] byte_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    input  logic [7:0]            mem_data_out,
    mem_to_axis_reader_if.master  m00_axis
);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   remaining_r;
    logic [ADDR_WIDTH-1:0]   rem_src_s;
    logic [2:0]              beat_n_r;
    logic [2:0]              beat_n_next_s;
    logic [2:0]              issue_idx_r;
    logic                    beat_start_s;
    logic                    cap_en_r;
    logic [1:0]              cap_lane_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    mem_read_en_r;
    logic                    tvalid_r;
    logic                    tlast_r;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_s;
    logic [BYTES_PER_BEAT-1:0]     strb_s;

    // State register.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (byte_count != '0) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (issue_idx_r == (beat_n_r - 3'd1)) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_CAPTURE: state_next_s = ST_VALID;
            ST_VALID: begin
                if (m00_axis.tready) begin
                    if (remaining_r == '0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_VALID;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Beat size is taken from the count latched at start or what is left after the previous beat.
    always_comb begin
        rem_src_s     = (state_r == ST_IDLE) ? byte_count : remaining_r;
        beat_n_next_s = (rem_src_s >= ADDR_WIDTH'(4)) ? 3'd4 : rem_src_s[2:0];
        beat_start_s  = (state_next_s == ST_FETCH) && (state_r != ST_FETCH);
    end

    // Address and remaining-byte counters; address wraps naturally at the top of memory.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            addr_r      <= '0;
            remaining_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            addr_r      <= base_addr;
            remaining_r <= byte_count;
        end else if (state_r == ST_FETCH) begin
            addr_r      <= addr_r + ADDR_WIDTH'(1);
            remaining_r <= remaining_r - ADDR_WIDTH'(1);
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    // Per-beat read issue tracking; each issued read lands in its lane one cycle later.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            beat_n_r    <= 3'd0;
            issue_idx_r <= 3'd0;
            cap_en_r    <= 1'b0;
            cap_lane_r  <= 2'd0;
        end else begin
            if (beat_start_s) begin
                beat_n_r    <= beat_n_next_s;
                issue_idx_r <= 3'd0;
            end else if (state_r == ST_FETCH) begin
                issue_idx_r <= issue_idx_r + 3'd1;
            end else begin
                issue_idx_r <= issue_idx_r;
            end
            cap_en_r   <= (state_r == ST_FETCH);
            cap_lane_r <= issue_idx_r[1:0];
        end
    end

    // Registered status/strobe outputs, decoded from the state being entered.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_read_en_r <= 1'b0;
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
        end else begin
            busy_r        <= (state_next_s == ST_FETCH) || (state_next_s == ST_CAPTURE) ||
                             (state_next_s == ST_VALID);
            done_r        <= (state_next_s == ST_DONE);
            mem_read_en_r <= (state_next_s == ST_FETCH);
            tvalid_r      <= (state_next_s == ST_VALID);
            tlast_r       <= (state_next_s == ST_VALID) && (remaining_r == '0);
        end
    end

    mem_axis_byte_packer u_packer (
        .clk        (m00_axis_aclk),
        .rst_n      (m00_axis_aresetn),
        .clear      (beat_start_s),
        .beat_n     (beat_n_next_s),
        .capture_en (cap_en_r),
        .lane       (cap_lane_r),
        .byte_in    (mem_data_out),
        .data       (data_s),
        .strb       (strb_s)
    );

    assign busy            = busy_r;
    assign done            = done_r;
    assign mem_addr        = addr_r;
    assign mem_read_en     = mem_read_en_r;
    assign m00_axis.tdata  = data_s;
    assign m00_axis.tstrb  = strb_s;
    assign m00_axis.tvalid = tvalid_r;
    assign m00_axis.tlast  = tlast_r;

endmodule

// File: tb/tb_mem_to_axis_reader.sv
// Self-checking bench: directed and random runs compared against a
// byte-array reference of the expected read addresses and packed beats.
module tb_mem_to_axis_reader;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] byte_count;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [7:0]  mem_data_out;

    logic [7:0]  mem [0:65535];

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;
    int stall_seen = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_valid_cyc = -1;
    int hs_cyc = -1;
    int start_cyc = 0;
    logic [15:0] obs_addr [$];
    beat_t       obs_beats [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [3:0]  prev_strb = 4'd0;
    logic        prev_last = 1'b0;

    mem_to_axis_reader_if #(.DATA_WIDTH(32)) axis ();

    mem_to_axis_reader #(.C_AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .byte_count       (byte_count),
        .busy             (busy),
        .done             (done),
        .mem_addr         (mem_addr),
        .mem_read_en      (mem_read_en),
        .mem_data_out     (mem_data_out),
        .m00_axis         (axis)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte-wide memory with one-cycle read latency.
    initial begin
        mem_data_out = 8'd0;
        forever begin
            @(posedge clk);
            if (mem_read_en) mem_data_out <= mem[mem_addr];
        end
    end

    // Downstream ready: always, random, or a 10-cycle stall on the first valid beat.
    initial begin
        axis.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: axis.tready = 1'b1;
                1: axis.tready = 1'($urandom_range(0, 1));
                default: begin
                    if (axis.tvalid && stall_cnt < 10) begin
                        axis.tready = 1'b0;
                        stall_cnt++;
                    end else begin
                        axis.tready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: records reads, handshakes and done; checks stall stability.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_read_en) obs_addr.push_back(mem_addr);
            if (axis.tvalid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check_eq("read_while_valid", 32'(mem_read_en), 32'd0);
            end
            if (prev_stall) begin
                check_eq("stall_tvalid", 32'(axis.tvalid), 32'd1);
                check_eq("stall_tdata", axis.tdata, prev_data);
                check_eq("stall_tstrb", 32'(axis.tstrb), 32'(prev_strb));
                check_eq("stall_tlast", 32'(axis.tlast), 32'(prev_last));
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_strb  = axis.tstrb;
            prev_last  = axis.tlast;
            if (axis.tvalid && !axis.tready) stall_seen++;
            if (axis.tvalid && axis.tready) begin
                beat_t b;
                b.data = axis.tdata;
                b.strb = axis.tstrb;
                b.last = axis.tlast;
                obs_beats.push_back(b);
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_beats.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        hs_cyc = -1;
        stall_seen = 0;
        stall_cnt = 0;
    endtask

    task automatic run_cmd(input logic [15:0] base, input logic [15:0] cnt, input int mode, input string name);
        logic [15:0] exp_addr [$];
        beat_t       exp_beats [$];
        int          guard;
        int          nfirst;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            exp_addr.push_back(a);
        end
        for (int b = 0; b * 4 < int'(cnt); b++) begin
            beat_t bt;
            int    n;
            n = (int'(cnt) - 4 * b >= 4) ? 4 : int'(cnt) - 4 * b;
            bt.data = 32'd0;
            for (int k = 0; k < n; k++) begin
                logic [15:0] a;
                a = base + 16'(4 * b + k);
                bt.data = bt.data | (32'(mem[a]) << (8 * k));
            end
            bt.strb = 4'((1 << n) - 1);
            bt.last = (4 * b + n == int'(cnt));
            exp_beats.push_back(bt);
        end
        nfirst = (int'(cnt) >= 4) ? 4 : int'(cnt);

        clear_obs();
        rdy_mode = mode;
        @(posedge clk); #1;
        base_addr  = base;
        byte_count = cnt;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = 16'($urandom);
        byte_count = 16'($urandom);
        @(negedge clk);
        check_eq({name, ":busy_after_start"}, 32'(busy), 32'(cnt != 16'd0));
        if (cnt != 16'd0) begin
            // A start pulse mid-run must be ignored.
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt == 0) check_eq({name, ":timeout"}, 32'd0, 32'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);

        check_eq({name, ":read_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            check_eq({name, ":read_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
        check_eq({name, ":beat_count"}, 32'(obs_beats.size()), 32'(exp_beats.size()));
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
            check_eq({name, ":tdata"}, obs_beats[i].data, exp_beats[i].data);
            check_eq({name, ":tstrb"}, 32'(obs_beats[i].strb), 32'(exp_beats[i].strb));
            check_eq({name, ":tlast"}, 32'(obs_beats[i].last), 32'(exp_beats[i].last));
        end
        check_eq({name, ":done_pulses"}, 32'(done_cnt), 32'd1);
        if (cnt == 16'd0) begin
            check_eq({name, ":done_latency"}, 32'(done_cyc - start_cyc), 32'd1);
            check_eq({name, ":no_tvalid"}, 32'(first_valid_cyc), 32'hFFFF_FFFF);
        end else begin
            check_eq({name, ":first_valid_latency"}, 32'(first_valid_cyc - start_cyc), 32'(nfirst + 2));
            check_eq({name, ":done_after_last_hs"}, 32'(done_cyc - hs_cyc), 32'd1);
        end
        if (mode == 2) check_eq({name, ":stall_cycles"}, 32'(stall_seen), 32'd10);
    endtask

    task automatic check_outputs_zero(input string name);
        check_eq({name, ":busy"}, 32'(busy), 32'd0);
        check_eq({name, ":done"}, 32'(done), 32'd0);
        check_eq({name, ":mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({name, ":mem_read_en"}, 32'(mem_read_en), 32'd0);
        check_eq({name, ":tdata"}, axis.tdata, 32'd0);
        check_eq({name, ":tstrb"}, 32'(axis.tstrb), 32'd0);
        check_eq({name, ":tvalid"}, 32'(axis.tvalid), 32'd0);
        check_eq({name, ":tlast"}, 32'(axis.tlast), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = 16'd0;
        byte_count = 16'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_cmd(16'h0010, 16'd8, 0, "two_full_beats");
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'hA0 + i);
        run_cmd(16'h0000, 16'd6, 0, "partial_last");
        run_cmd(16'h0000, 16'd0, 0, "zero_count");
        run_cmd(16'hFFFE, 16'd4, 0, "addr_wrap");
        run_cmd(16'h0020, 16'd4, 2, "tready_stall");

        // Abort mid-fetch with an asynchronous reset.
        clear_obs();
        rdy_mode = 0;
        @(posedge clk); #1;
        base_addr  = 16'h0100;
        byte_count = 16'd12;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(posedge clk);
        check_eq("mid_reset:beats", 32'(obs_beats.size()), 32'd0);
        check_eq("mid_reset:done", 32'(done_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        run_cmd(16'h0200, 16'd4, 0, "after_reset");

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int r = 0; r < 25; r++) begin
            logic [15:0] rb;
            logic [15:0] rc;
            rb = 16'($urandom);
            rc = 16'($urandom_range(0, 20));
            run_cmd(rb, rc, int'($urandom_range(0, 1)), "random");
        end
        run_cmd(16'hFFFD, 16'd11, 1, "random_wrap");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
